unidade_funcional: RTL and testbench
====================================

UNIDADE_FUNCIONAL -- requirements
Module: unidade_funcional

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data/instruction width.
REQ-002 SHALL have parameter ARITH_LAT, default 2, cycles from accept to done for add/sub.
REQ-003 SHALL have parameter MEM_LAT, default 3, cycles from accept to done for ld/sd.
REQ-004 SHALL have port Clock, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port Reset, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port instOut, input, 16, instruction issued by the reservation station.
REQ-007 SHALL have port instOutEnable, input, 1, issue strobe.
REQ-008 SHALL have port instructionCodeIn, input, 3, reservation-station line tag of the issued instruction.
REQ-009 SHALL have port reg1, input, 16, operand selected by instruction field Rx [6:4].
REQ-010 SHALL have port reg2, input, 16, operand selected by instruction field Ry [9:7].
REQ-011 SHALL have port instructionCodeOut, output, 3, tag of the completing instruction.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port doneInst, output, 16, completing instruction word.
REQ-014 SHALL have port dout, output, 16, result.
REQ-015 SHALL have port disponivelUF, output, 1, unit free to accept an issue.

Function
REQ-016 SHALL decode instOut[3:0]: 0000 = add, 0001 = sub, any other = ld/sd; Rz = [12:10], Ry = [9:7], Rx = [6:4].
REQ-017 SHALL accept an issue on a rising edge when instOutEnable=1 and disponivelUF=1, latching instOut, instructionCodeIn, reg1 and reg2.
REQ-018 SHALL ignore instOutEnable while disponivelUF=0; the in-flight operation SHALL be unaffected.
REQ-019 SHALL drive disponivelUF=0 from the edge after acceptance until the completion cycle.
REQ-020 SHALL drive disponivelUF=1 in the completion cycle, so a back-to-back issue is accepted on the same edge that ends the done pulse.
REQ-021 SHALL compute add as reg2+reg1 and sub as reg2-reg1, truncated modulo 2^16 with no carry or overflow output.
REQ-022 SHALL compute ld/sd as dout = reg2 (pass-through).
REQ-023 SHALL assert done for exactly one cycle, ARITH_LAT (add/sub) or MEM_LAT (ld/sd) cycles after the accepting edge.
REQ-024 SHALL update dout, doneInst and instructionCodeOut on the edge that raises done, and hold them until the next completion.
REQ-025 SHALL never assert done without a preceding accepted issue.
REQ-026 SHALL provide sub-module mux: inputs R1..R7 (16 bits each), 3-bit sel, 16-bit output; it is purely combinational.
REQ-027 SHALL make mux output Rn for sel=n (1..7) and 0 for sel=000.

Reset
REQ-028 SHALL, while Reset=0 and regardless of Clock, force done=0, dout=0, doneInst=0, instructionCodeOut=0, disponivelUF=1 and clear the latency counter.
REQ-029 SHALL abort an in-flight operation when reset is asserted mid-operation; no done pulse SHALL follow for it after release.
REQ-030 SHALL accept issues from the first rising edge after Reset returns to 1.

Structure
REQ-031 SHALL place opcode constants (OP_ADD=4'b0000, OP_SUB=4'b0001), field bit positions and the default latencies in a shared package used by the unit and the reservation station.
REQ-032 SHALL implement the datapath as one module with one internal down-counter and busy flag.
REQ-033 SHALL keep mux as a separate module instantiated by the reservation station, outside unidade_funcional.

Verification
REQ-034 SHALL verify add: instOut=16'h0000 (add), reg2=5, reg1=3, tag=2 -> done 2 cycles later with dout=8, instructionCodeOut=2, doneInst=16'h0000.
REQ-035 SHALL verify sub wrap: sub with reg2=1, reg1=2 -> dout=16'hFFFF; add with 16'hFFFF+1 -> dout=0.
REQ-036 SHALL verify ld: instOut[3:0]=0010, reg2=16'h1234 -> done 3 cycles later with dout=16'h1234.
REQ-037 SHALL verify busy: a second issue during the busy window is dropped (single done, first result); an issue in the done cycle is accepted and completes.
REQ-038 SHALL verify reset: Reset=0 one cycle after accept -> no done, disponivelUF=1, all outputs 0.
REQ-039 SHALL verify mux: R1..R7=11..17 -> sel=1..7 yields 11..17; sel=0 yields 0.

Source files
------------

// File: rtl/unidade_funcional_pkg.sv
// Shared opcode constants, instruction field positions and default latencies
// for the functional unit and the reservation station that feeds it.
package unidade_funcional_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int RX_LSB  = 4;
  localparam int RX_MSB  = 6;
  localparam int RY_LSB  = 7;
  localparam int RY_MSB  = 9;
  localparam int RZ_LSB  = 10;
  localparam int RZ_MSB  = 12;

  localparam int DEF_ARITH_LAT = 2;
  localparam int DEF_MEM_LAT   = 3;

  typedef enum logic [1:0] {
    KIND_ADD,
    KIND_SUB,
    KIND_MEM
  } op_kind_t;

  // Every opcode other than add/sub is treated as a load/store.
  function automatic op_kind_t decode_op(input logic [3:0] opc);
    case (opc)
      OP_ADD:  decode_op = KIND_ADD;
      OP_SUB:  decode_op = KIND_SUB;
      default: decode_op = KIND_MEM;
    endcase
  endfunction

endpackage

// File: rtl/unidade_funcional_mux.sv
// Register-file operand selector used by the reservation station.
// Selector value 0 denotes register zero and therefore yields a constant 0.
module mux #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  input  logic [WIDTH-1:0] R4,
  input  logic [WIDTH-1:0] R5,
  input  logic [WIDTH-1:0] R6,
  input  logic [WIDTH-1:0] R7,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    case (sel)
      3'd1:    dout = R1;
      3'd2:    dout = R2;
      3'd3:    dout = R3;
      3'd4:    dout = R4;
      3'd5:    dout = R5;
      3'd6:    dout = R6;
      3'd7:    dout = R7;
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/unidade_funcional.sv
// Pipelined-latency functional unit: accepts one instruction at a time and
// reports its result after a fixed add/sub or load/store latency.
module unidade_funcional
  import unidade_funcional_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ARITH_LAT = DEF_ARITH_LAT,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] instOut,
  input  logic             instOutEnable,
  input  logic [2:0]       instructionCodeIn,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic [2:0]       instructionCodeOut,
  output logic             done,
  output logic [WIDTH-1:0] doneInst,
  output logic [WIDTH-1:0] dout,
  output logic             disponivelUF
);

  localparam int CW = 8;

  logic [WIDTH-1:0] inst_q;
  logic [2:0]       tag_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [CW-1:0]    issue_lat;
  logic [WIDTH-1:0] result;

  assign disponivelUF = ~busy;

  always_comb begin
    issue_lat = CW'(MEM_LAT);
    if (decode_op(instOut[OPC_MSB:OPC_LSB]) != KIND_MEM)
      issue_lat = CW'(ARITH_LAT);
  end

  always_comb begin
    result = r2_q;
    case (decode_op(inst_q[OPC_MSB:OPC_LSB]))
      KIND_ADD: result = r2_q + r1_q;
      KIND_SUB: result = r2_q - r1_q;
      default:  result = r2_q;
    endcase
  end

  // The counter is loaded with the full latency on acceptance; the edge that
  // sees it at 1 publishes the result and frees the unit in the same cycle,
  // which is what lets a new issue land on the edge that ends the done pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inst_q             <= '0;
      tag_q              <= '0;
      r1_q               <= '0;
      r2_q               <= '0;
      cnt                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      dout               <= '0;
      doneInst           <= '0;
      instructionCodeOut <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy               <= 1'b0;
          done               <= 1'b1;
          dout               <= result;
          doneInst           <= inst_q;
          instructionCodeOut <= tag_q;
        end
      end else if (instOutEnable) begin
        inst_q <= instOut;
        tag_q  <= instructionCodeIn;
        r1_q   <= reg1;
        r2_q   <= reg2;
        cnt    <= issue_lat;
        busy   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unidade_funcional.sv
// Self-checking bench for unidade_funcional and the operand mux, comparing
// against a completion-time model of the unit.
module tb_unidade_funcional;
  import unidade_funcional_pkg::*;

  localparam int W = 16;

  logic          Clock;
  logic          Reset;
  logic [W-1:0]  instOut;
  logic          instOutEnable;
  logic [2:0]    instructionCodeIn;
  logic [W-1:0]  reg1;
  logic [W-1:0]  reg2;
  logic [2:0]    instructionCodeOut;
  logic          done;
  logic [W-1:0]  doneInst;
  logic [W-1:0]  dout;
  logic          disponivelUF;

  logic [W-1:0]  mR [1:7];
  logic [2:0]    mSel;
  logic [W-1:0]  mOut;

  int testsRun  = 0;
  int testsFail = 0;

  // Model: a pending instruction completes at a known edge number.
  int            edgeCount = 0;
  bit            pending   = 0;
  int            doneAt    = 0;
  logic [W-1:0]  pendRes, pendInst;
  logic [2:0]    pendTag;
  logic          expDone;
  logic [W-1:0]  expDout, expInst;
  logic [2:0]    expTag;

  unidade_funcional #(.WIDTH(W), .ARITH_LAT(2), .MEM_LAT(3)) dut (
    .Clock(Clock), .Reset(Reset), .instOut(instOut), .instOutEnable(instOutEnable),
    .instructionCodeIn(instructionCodeIn), .reg1(reg1), .reg2(reg2),
    .instructionCodeOut(instructionCodeOut), .done(done), .doneInst(doneInst),
    .dout(dout), .disponivelUF(disponivelUF)
  );

  mux #(.WIDTH(W)) muxDut (
    .R1(mR[1]), .R2(mR[2]), .R3(mR[3]), .R4(mR[4]), .R5(mR[5]), .R6(mR[6]), .R7(mR[7]),
    .sel(mSel), .dout(mOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] refResult(input logic [W-1:0] inst,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s;
    if (inst[3:0] == 4'b0000)      s = int'(b) + int'(a);
    else if (inst[3:0] == 4'b0001) s = int'(b) + 65536 - int'(a);
    else                           s = int'(b);
    return W'(s % 65536);
  endfunction

  task automatic checkOutput(input string tag);
    check({tag, ".done"}, W'(done), W'(expDone));
    check({tag, ".dout"}, dout, expDout);
    check({tag, ".doneInst"}, doneInst, expInst);
    check({tag, ".tag"}, W'(instructionCodeOut), W'(expTag));
    check({tag, ".free"}, W'(disponivelUF), W'(!pending));
  endtask

  // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic applyStimulus(input string tag, input logic en, input logic [W-1:0] inst,
                               input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    bit accept;
    instOut = inst; instOutEnable = en; instructionCodeIn = code; reg1 = a; reg2 = b;
    accept = en && !pending;
    @(posedge Clock);
    edgeCount++;
    expDone = 1'b0;
    if (pending && edgeCount == doneAt) begin
      pending = 0;
      expDone = 1'b1;
      expDout = pendRes; expInst = pendInst; expTag = pendTag;
    end
    if (accept) begin
      pending  = 1;
      doneAt   = edgeCount + ((inst[3:0] == 4'b0000 || inst[3:0] == 4'b0001) ? 2 : 3);
      pendRes  = refResult(inst, a, b);
      pendInst = inst;
      pendTag  = code;
    end
    @(negedge Clock);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic applyReset(input string tag);
    Reset = 1'b0;
    instOutEnable = 1'b0;
    #1;
    pending = 0; expDone = 0; expDout = '0; expInst = '0; expTag = '0;
    checkOutput({tag, ".async"});
    @(posedge Clock);
    edgeCount++;
    @(negedge Clock);
    checkOutput({tag, ".held"});
    Reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ri, ra, rb;
    Reset = 1'b1; instOut = '0; instOutEnable = 1'b0; instructionCodeIn = '0;
    reg1 = '0; reg2 = '0; mSel = '0;
    for (int i = 1; i <= 7; i++) mR[i] = W'(10 + i);
    @(negedge Clock);
    applyReset("reset");

    applyStimulus("add.issue", 1'b1, 16'h0000, 3'd2, 16'd3, 16'd5);
    applyStimulus("add.wait", 1'b0, '0, '0, '0, '0);
    applyStimulus("add.done", 1'b0, '0, '0, '0, '0);
    check("add.const", dout, 16'd8);
    check("add.pulse", W'(done), W'(1'b1));
    idle("add.after", 1);

    applyStimulus("sub.issue", 1'b1, 16'h0001, 3'd5, 16'd2, 16'd1);
    idle("sub.wait", 2);
    check("sub.wrap", dout, 16'hFFFF);
    applyStimulus("addw.issue", 1'b1, 16'h1C70, 3'd1, 16'd1, 16'hFFFF);
    idle("addw.wait", 2);
    check("add.wrap", dout, 16'h0000);

    applyStimulus("ld.issue", 1'b1, 16'h0002, 3'd7, 16'hAAAA, 16'h1234);
    idle("ld.wait", 3);
    check("ld.const", dout, 16'h1234);

    applyStimulus("busy.first", 1'b1, 16'h0000, 3'd3, 16'd10, 16'd20);
    applyStimulus("busy.drop", 1'b1, 16'h0001, 3'd4, 16'd1, 16'd100);
    applyStimulus("busy.done", 1'b0, '0, '0, '0, '0);
    check("busy.result", dout, 16'd30);
    applyStimulus("b2b.issue", 1'b1, 16'h0001, 3'd6, 16'd4, 16'd9);
    idle("b2b.wait", 2);
    check("b2b.result", dout, 16'd5);
    idle("b2b.after", 1);

    applyStimulus("rst.issue", 1'b1, 16'h0003, 3'd1, 16'd1, 16'h5555);
    applyReset("rst.mid");
    idle("rst.quiet", 4);

    for (int i = 0; i < 80; i++) begin
      ri = W'($urandom);
      ri[3:0] = 4'($urandom_range(0, 3));
      ra = W'($urandom); rb = W'($urandom);
      applyStimulus("rand", 1'($urandom_range(0, 2) != 0), ri, 3'($urandom), ra, rb);
    end
    idle("rand.drain", 4);

    for (int s = 0; s < 8; s++) begin
      mSel = 3'(s);
      #1;
      check("mux", mOut, (s == 0) ? W'(0) : W'(10 + s));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
